// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, fetches over a req/ack
// handshake, loads IF/ID, squashes wrong-path responses and buffers one word under stall.
module fetch_stage #(
    parameter int unsigned                PC_WIDTH = 32,
    parameter int unsigned                IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]        RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_change_pc,
    input  logic [PC_WIDTH-1:0] i_pc_target,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [IWIDTH-1:0]   i_imem_data,
    output logic                o_valid,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [IWIDTH-1:0]   o_instr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                state_q,   state_d;
    logic                  req_q,     req_d;
    logic [PC_WIDTH-1:0]   addr_q,    addr_d;
    logic [PC_WIDTH-1:0]   redir_q,   redir_d;
    logic                  squash_q,  squash_d;
    logic [IWIDTH-1:0]     hold_q,    hold_d;
    logic [PC_WIDTH-1:0]   hold_pc_q, hold_pc_d;
    logic                  valid_q,   valid_d;
    logic [PC_WIDTH-1:0]   pc_q,      pc_d;
    logic [IWIDTH-1:0]     instr_q,   instr_d;

    logic                  ifid_free_s;
    logic [PC_WIDTH-1:0]   addr_inc_s;

    assign ifid_free_s = !valid_q || !i_stall;
    assign addr_inc_s  = addr_q + PC_WIDTH'(1);

    // Next-state, PC and IF/ID update logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        redir_d   = redir_q;
        squash_d  = squash_q;
        hold_d    = hold_q;
        hold_pc_d = hold_pc_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (i_change_pc) begin
                    addr_d = i_pc_target;
                end else begin
                    addr_d = addr_q;
                end
            end

            ST_REQ: begin
                if (i_imem_ack) begin
                    if (i_change_pc) begin
                        addr_d   = i_pc_target;
                        squash_d = 1'b0;
                        valid_d  = 1'b0;
                        instr_d  = '0;
                    end else if (squash_q) begin
                        // Response belongs to the wrong path; resume at the saved target.
                        addr_d   = redir_q;
                        squash_d = 1'b0;
                        if (ifid_free_s) begin
                            valid_d = 1'b0;
                            instr_d = '0;
                        end else begin
                            valid_d = valid_q;
                        end
                    end else if (ifid_free_s) begin
                        valid_d = 1'b1;
                        pc_d    = addr_q;
                        instr_d = i_imem_data;
                        addr_d  = addr_inc_s;
                    end else begin
                        hold_d    = i_imem_data;
                        hold_pc_d = addr_q;
                        addr_d    = addr_inc_s;
                        state_d   = ST_HOLD;
                    end
                end else begin
                    if (i_change_pc) begin
                        // Request still in flight: keep the address, drop its reply later.
                        redir_d  = i_pc_target;
                        squash_d = 1'b1;
                        valid_d  = 1'b0;
                        instr_d  = '0;
                    end else if (valid_q && !i_stall) begin
                        valid_d = 1'b0;
                        instr_d = '0;
                    end else begin
                        valid_d = valid_q;
                    end
                end
            end

            ST_HOLD: begin
                if (i_change_pc) begin
                    valid_d = 1'b0;
                    instr_d = '0;
                    addr_d  = i_pc_target;
                    state_d = ST_REQ;
                end else if (!i_stall) begin
                    valid_d = 1'b1;
                    pc_d    = hold_pc_q;
                    instr_d = hold_q;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d = (state_d == ST_REQ);
    end

    // State and pipeline registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            redir_q   <= '0;
            squash_q  <= 1'b0;
            hold_q    <= '0;
            hold_pc_q <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            redir_q   <= redir_d;
            squash_q  <= squash_d;
            hold_q    <= hold_d;
            hold_pc_q <= hold_pc_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
        end
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = addr_q;
    assign o_valid     = valid_q;
    assign o_pc        = pc_q;
    assign o_instr     = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory answers data = addr + 0x100, with
// bench-controlled ack enable to model wait states and stray acks.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        chg;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;

    logic        ack_en;
    logic        ack_force;

    int n_checks;
    int n_pass;

    assign ack  = ack_force | (req & ack_en);
    assign data = addr + 32'h0000_0100;

    fetch_stage #(
        .PC_WIDTH (32),
        .IWIDTH   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_change_pc (chg),
        .i_pc_target (tgt),
        .o_imem_req  (req),
        .o_imem_addr (addr),
        .i_imem_ack  (ack),
        .i_imem_data (data),
        .o_valid     (valid),
        .o_pc        (pc),
        .o_instr     (instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_req"},   {31'd0, req},   32'd0);
        check_eq({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check_eq({tag, "_pc"},    pc,             32'd0);
        check_eq({tag, "_instr"}, instr,          32'd0);
        check_eq({tag, "_addr"},  addr,           32'd0);
    endtask

    task automatic redirect(input logic [31:0] target);
        chg = 1'b1;
        tgt = target;
        step();
        chg = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        chg       = 1'b0;
        tgt       = 32'd0;
        ack_en    = 1'b1;
        ack_force = 1'b0;

        // Reset state, then zero-wait streaming.
        step();
        step();
        check_zero("rst");
        rst = 1'b0;
        step();
        check_eq("first_req",  {31'd0, req},   32'd1);
        check_eq("first_addr", addr,           32'd0);
        check_eq("first_vld",  {31'd0, valid}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("zw_valid", {31'd0, valid}, 32'd1);
            check_eq("zw_pc",    pc,             32'(i));
            check_eq("zw_instr", instr,          32'h100 + 32'(i));
            step();
        end

        // Two wait states per fetch, addresses 5..7.
        for (int k = 5; k < 8; k++) begin
            ack_en = 1'b0;
            step();
            check_eq("lat_vld0",  {31'd0, valid}, 32'd0);
            check_eq("lat_addr0", addr,           32'(k));
            step();
            check_eq("lat_addr1", addr,           32'(k));
            check_eq("lat_vld1",  {31'd0, valid}, 32'd0);
            ack_en = 1'b1;
            step();
            check_eq("lat_valid", {31'd0, valid}, 32'd1);
            check_eq("lat_pc",    pc,             32'(k));
            check_eq("lat_instr", instr,          32'h100 + 32'(k));
        end

        // Redirect coincident with ack of addr 8.
        check_eq("rd_pre_addr", addr, 32'd8);
        redirect(32'h40);
        check_eq("rd_addr",  addr,           32'h40);
        check_eq("rd_vld",   {31'd0, valid}, 32'd0);
        check_eq("rd_instr", instr,          32'd0);
        step();
        check_eq("rd_valid", {31'd0, valid}, 32'd1);
        check_eq("rd_pc",    pc,             32'h40);
        check_eq("rd_ins",   instr,          32'h140);

        // Redirect to 0x80 while addr 3 is outstanding.
        redirect(32'd3);
        ack_en = 1'b0;
        check_eq("pend_addr", addr, 32'd3);
        redirect(32'h80);
        check_eq("pend_hold0", addr,           32'd3);
        check_eq("pend_vld0",  {31'd0, valid}, 32'd0);
        step();
        check_eq("pend_hold1", addr,           32'd3);
        ack_en = 1'b1;
        step();
        check_eq("pend_tgt",   addr,           32'h80);
        check_eq("pend_vld2",  {31'd0, valid}, 32'd0);
        step();
        check_eq("pend_valid", {31'd0, valid}, 32'd1);
        check_eq("pend_pc",    pc,             32'h80);
        check_eq("pend_instr", instr,          32'h180);

        // Stall with pc 10 in IF/ID for four cycles.
        redirect(32'd10);
        step();
        check_eq("st_pc0", pc, 32'd10);
        stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            check_eq("st_pc",    pc,             32'd10);
            check_eq("st_valid", {31'd0, valid}, 32'd1);
            check_eq("st_req",   {31'd0, req},   32'd0);
        end
        stall = 1'b0;
        step();
        check_eq("st_rel_pc",    pc,    32'd11);
        check_eq("st_rel_instr", instr, 32'h10B);
        step();
        check_eq("st_next_pc",    pc,    32'd12);
        check_eq("st_next_instr", instr, 32'h10C);

        // Redirect while holding pc 13: the held word is discarded.
        stall = 1'b1;
        step();
        check_eq("hr_req", {31'd0, req}, 32'd0);
        check_eq("hr_pc",  pc,           32'd12);
        redirect(32'h60);
        check_eq("hr_vld",   {31'd0, valid}, 32'd0);
        check_eq("hr_instr", instr,          32'd0);
        check_eq("hr_addr",  addr,           32'h60);
        stall = 1'b0;
        step();
        check_eq("hr_pc_tgt", pc,             32'h60);
        check_eq("hr_valid",  {31'd0, valid}, 32'd1);

        // Asynchronous reset while addr 0x20 is outstanding, with a stray ack.
        redirect(32'h20);
        ack_en = 1'b0;
        step();
        check_eq("ar_addr", addr, 32'h20);
        #2;
        rst       = 1'b1;
        ack_force = 1'b1;
        #1;
        check_zero("ar");
        step();
        rst = 1'b0;
        step();
        check_eq("ar_ign_vld", {31'd0, valid}, 32'd0);
        check_eq("ar_req",     {31'd0, req},   32'd1);
        check_eq("ar_addr0",   addr,           32'd0);
        ack_force = 1'b0;
        ack_en    = 1'b1;
        step();
        check_eq("ar_valid", {31'd0, valid}, 32'd1);
        check_eq("ar_pc",    pc,             32'd0);
        check_eq("ar_instr", instr,          32'h100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
